// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: drives a synchronous one-cycle ROM, tracks the
// in-flight read, and presents (pc, inst, valid) to IF/ID with stall holding.
module if_fetch_ctrl #(
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  rom_ce_o,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_inst_i,
   output logic [ADDR_WIDTH-1:0] if_pc_o,
   output logic [DATA_WIDTH-1:0] if_inst_o,
   output logic                  if_valid_o,
   output logic                  misalign_o
);

   typedef enum logic {StIdle, StRun} st_e;

   st_e                   st_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] resp_pc_q;
   logic                  resp_valid_q;
   logic                  held_q;
   logic [DATA_WIDTH-1:0] hold_inst_q;
   logic                  misalign_q;

   logic                  fetch_en;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [ADDR_WIDTH-1:0] redirect_aligned;

   // Fetch enable, sequential successor and aligned redirect target.
   always_comb begin
      fetch_en         = (st_q == StRun);
      pc_inc           = pc_q + ADDR_WIDTH'(4);
      redirect_aligned = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
   end

   // All state: FSM, PC, response tracking and stall capture.
   // Priority each edge: redirect, then stall, then advance.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         st_q         <= StIdle;
         pc_q         <= RESET_PC;
         resp_pc_q    <= RESET_PC;
         resp_valid_q <= 1'b0;
         held_q       <= 1'b0;
         hold_inst_q  <= '0;
         misalign_q   <= 1'b0;
      end else begin
         // IDLE lasts exactly one cycle, independent of stall/redirect.
         st_q       <= StRun;
         misalign_q <= 1'b0;
         if (redirect_i) begin
            // Killing resp_valid_q drops the fetch already in flight.
            pc_q         <= redirect_aligned;
            resp_valid_q <= 1'b0;
            held_q       <= 1'b0;
            misalign_q   <= (redirect_pc_i[1:0] != 2'b00);
         end else if (stall_i) begin
            // ROM re-reads pc_q during the stall; only the presented word needs capturing.
            if (resp_valid_q && !held_q) begin
               hold_inst_q <= rom_inst_i;
               held_q      <= 1'b1;
            end
         end else begin
            resp_pc_q    <= pc_q;
            resp_valid_q <= fetch_en;
            held_q       <= 1'b0;
            if (fetch_en) begin
               pc_q <= pc_inc;
            end
         end
      end
   end

   // Outputs decode directly from registered state.
   always_comb begin
      rom_ce_o   = fetch_en;
      rom_addr_o = pc_q;
      if_pc_o    = resp_pc_q;
      if_valid_o = resp_valid_q;
      if_inst_o  = held_q ? hold_inst_q : rom_inst_i;
      misalign_o = misalign_q;
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: stimulus queues expected (pc, inst)
// pairs, a negedge monitor compares whatever the DUT presents as valid.
module tb_if_fetch_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        rom_ce_o;
   logic [31:0] rom_addr_o;
   logic [31:0] rom_inst_i = '0;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;
   logic        misalign_o;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   if_fetch_ctrl #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .RESET_PC  (32'h0000_0000)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .rom_ce_o     (rom_ce_o),
      .rom_addr_o   (rom_addr_o),
      .rom_inst_i   (rom_inst_i),
      .if_pc_o      (if_pc_o),
      .if_inst_o    (if_inst_o),
      .if_valid_o   (if_valid_o),
      .misalign_o   (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous ROM model: word n holds value n.
   always @(posedge clk_i) begin
      if (rom_ce_o) rom_inst_i <= rom_addr_o >> 2;
   end

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Monitor: compare presented word to queue head; it leaves the queue when
   // accepted (no stall) or dropped by a redirect.
   always @(negedge clk_i) begin
      if (!rst_i && if_valid_o) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got pc %h expected no valid at %0t", if_pc_o, $time);
         end else begin
            check("mon_pc", if_pc_o, exp_q[0].pc);
            check("mon_inst", if_inst_o, exp_q[0].inst);
            if (!stall_i || redirect_i) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = pc >> 2;
      exp_q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ce"}, {31'b0, rom_ce_o}, 32'd0);
      check({tag, "_addr"}, rom_addr_o, 32'h0);
      check({tag, "_valid"}, {31'b0, if_valid_o}, 32'd0);
      check({tag, "_pc"}, if_pc_o, 32'h0);
      check({tag, "_misalign"}, {31'b0, misalign_o}, 32'd0);
      check({tag, "_inst"}, if_inst_o, rom_inst_i);
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
      #12;
      check_reset_outputs("rst0");
      tick();
      // Cycle 1 after release: IDLE.
      rst_i = 1'b0;
      push(32'h0); push(32'h4); push(32'h8);
      check("c1_ce", {31'b0, rom_ce_o}, 32'd0);
      tick();                                      // cycle 2
      check("c2_ce", {31'b0, rom_ce_o}, 32'd1);
      check("c2_addr", rom_addr_o, 32'h0);
      check("c2_valid", {31'b0, if_valid_o}, 32'd0);
      tick();                                      // cycle 3: (0,0)
      tick();                                      // cycle 4: (4,1)
      tick();                                      // cycle 5: (8,2), stall 3 edges
      stall_i = 1'b1;
      tick(); tick();                              // cycles 6,7 held
      tick();                                      // cycle 8: release, (8,2) accepted
      stall_i = 1'b0;
      push(32'hC);
      tick();                                      // cycle 9: (C,3), redirect 0x40
      redirect_i = 1'b1; redirect_pc_i = 32'h40;
      push(32'h40); push(32'h44);
      tick();                                      // cycle 10: bubble
      redirect_i = 1'b0;
      check("c10_valid", {31'b0, if_valid_o}, 32'd0);
      check("c10_misalign", {31'b0, misalign_o}, 32'd0);
      tick();                                      // cycle 11: (40,16)
      tick();                                      // cycle 12: (44,17), stall+redirect 0x42
      stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h42;
      push(32'h40); push(32'h44);
      tick();                                      // cycle 13: bubble
      stall_i = 1'b0; redirect_i = 1'b0;
      check("c13_valid", {31'b0, if_valid_o}, 32'd0);
      check("c13_misalign", {31'b0, misalign_o}, 32'd1);
      check("c13_addr", rom_addr_o, 32'h40);
      tick();                                      // cycle 14: (40,16)
      check("c14_misalign", {31'b0, misalign_o}, 32'd0);
      tick();                                      // cycle 15: (44,17), redirect top word
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      push(32'hFFFF_FFFC); push(32'h0);
      tick();                                      // cycle 16: bubble
      redirect_i = 1'b0;
      check("c16_valid", {31'b0, if_valid_o}, 32'd0);
      check("c16_addr", rom_addr_o, 32'hFFFF_FFFC);
      tick();                                      // cycle 17: (FFFFFFFC, 3FFFFFFF)
      check("c17_wrap_addr", rom_addr_o, 32'h0);
      tick();                                      // cycle 18: (0,0)
      push(32'h4);
      tick();                                      // cycle 19: (4,1)
      #6;                                          // past the monitor, off any edge
      rst_i = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      tick();
      // Redirect while IDLE, then stall while nothing is valid.
      rst_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h100;
      push(32'h100); push(32'h104);
      check("i1_ce", {31'b0, rom_ce_o}, 32'd0);
      tick();
      redirect_i = 1'b0; stall_i = 1'b1;
      check("i2_ce", {31'b0, rom_ce_o}, 32'd1);
      check("i2_addr", rom_addr_o, 32'h100);
      check("i2_valid", {31'b0, if_valid_o}, 32'd0);
      tick();
      stall_i = 1'b0;
      check("i3_valid", {31'b0, if_valid_o}, 32'd0);
      check("i3_addr", rom_addr_o, 32'h100);
      tick();                                      // (100,64)
      tick();                                      // (104,65)
      #6;
      rst_i = 1'b1;
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
